// File: rtl/sequenciador_programa_pkg.sv
// Shared definitions for the program sequencer: processor opcodes,
// instruction field positions and the sequencer state encoding.
package sequenciador_programa_pkg;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MVNZ = 3'b100;

    localparam int unsigned OPC_HI = 8;
    localparam int unsigned OPC_LO = 6;
    localparam int unsigned RX_HI  = 5;
    localparam int unsigned RX_LO  = 3;
    localparam int unsigned RY_HI  = 2;
    localparam int unsigned RY_LO  = 0;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        IMM,
        WAIT,
        HALT,
        ERRO
    } seq_state_e;

    function automatic logic [2:0] opcode_of(input logic [OPC_HI:0] word);
        return word[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/sequenciador_programa_memoria.sv
// Program memory: 2**ADDR_W words, synchronous write, asynchronous read,
// contents survive reset.
module memoria_programa
    import sequenciador_programa_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sequenciador_programa.sv
// Program sequencer: feeds stored words to the processor one instruction at
// a time (Run pulse, optional mvi immediate) and waits for Done to advance.
module sequenciador_programa
    import sequenciador_programa_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic [ADDR_W:0]   ProgLen,
    input  logic              Done,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    output logic [DATA_W-1:0] DIN,
    output logic              Run,
    output logic [ADDR_W:0]   PC,
    output logic              Busy,
    output logic              Halted,
    output logic              Erro
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    seq_state_e        state_q;
    logic [ADDR_W:0]   pc_q;
    logic [ADDR_W:0]   len_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              run_q;
    logic              halted_q;
    logic              erro_q;

    logic [DATA_W-1:0] mem_word;
    logic [ADDR_W:0]   pc_inc;
    logic              is_mvi;
    logic              busy;

    memoria_programa #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_i   (Clock),
        .we_i    (WrEn && !busy),
        .waddr_i (WrAddr),
        .wdata_i (WrData),
        .raddr_i (pc_q[ADDR_W-1:0]),
        .rdata_o (mem_word)
    );

    always_comb begin
        busy   = (state_q == ISSUE) || (state_q == IMM) || (state_q == WAIT);
        pc_inc = pc_q + 1'b1;
        is_mvi = (opcode_of(mem_word[OPC_HI:0]) == OP_MVI);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            halted_q <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            run_q <= 1'b0;
            case (state_q)
                IDLE, HALT, ERRO: begin
                    if (Start) begin
                        pc_q     <= '0;
                        halted_q <= 1'b0;
                        erro_q   <= 1'b0;
                        if (ProgLen != '0) begin
                            len_q   <= ProgLen;
                            state_q <= ISSUE;
                            run_q   <= 1'b1;
                        end else begin
                            state_q  <= HALT;
                            halted_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    cnt_q <= '0;
                    if (!is_mvi) begin
                        state_q <= WAIT;
                    end else if (pc_inc < len_q) begin
                        pc_q    <= pc_inc;
                        state_q <= IMM;
                    end else begin
                        state_q <= ERRO;
                        erro_q  <= 1'b1;
                    end
                end
                // IMM shares completion with WAIT; only WAIT runs the timeout.
                IMM, WAIT: begin
                    if (Done) begin
                        pc_q <= pc_inc;
                        if (pc_inc == len_q) begin
                            state_q  <= HALT;
                            halted_q <= 1'b1;
                        end else begin
                            state_q <= ISSUE;
                            run_q   <= 1'b1;
                        end
                    end else if (state_q == IMM) begin
                        state_q <= WAIT;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_q <= ERRO;
                        erro_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign DIN    = busy ? mem_word : '0;
    assign Run    = run_q;
    assign PC     = pc_q;
    assign Busy   = busy;
    assign Halted = halted_q;
    assign Erro   = erro_q;

endmodule

// File: tb/tb_sequenciador_programa.sv
// Directed self-checking bench for the program sequencer.
module tb_sequenciador_programa;

    logic        Clock;
    logic        Resetn;
    logic        Start;
    logic [5:0]  ProgLen;
    logic        Done;
    logic        WrEn;
    logic [4:0]  WrAddr;
    logic [15:0] WrData;
    logic [15:0] DIN;
    logic        Run;
    logic [5:0]  PC;
    logic        Busy;
    logic        Halted;
    logic        Erro;

    int total;
    int bad;

    sequenciador_programa #(
        .DATA_W  (16),
        .ADDR_W  (5),
        .TIMEOUT (15)
    ) dut (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .Start   (Start),
        .ProgLen (ProgLen),
        .Done    (Done),
        .WrEn    (WrEn),
        .WrAddr  (WrAddr),
        .WrData  (WrData),
        .DIN     (DIN),
        .Run     (Run),
        .PC      (PC),
        .Busy    (Busy),
        .Halted  (Halted),
        .Erro    (Erro)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(negedge Clock);
    endtask

    task automatic write_word(input logic [4:0] a, input logic [15:0] d);
        @(negedge Clock);
        WrEn = 1'b1; WrAddr = a; WrData = d;
        @(negedge Clock);
        WrEn = 1'b0;
    endtask

    // Returns at the negedge of the cycle right after the launch edge.
    task automatic start_prog(input logic [5:0] len);
        @(negedge Clock);
        Start = 1'b1; ProgLen = len;
        @(negedge Clock);
        Start = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++; if ({Run, Busy, Halted, Erro} !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b expected 0000", {Run, Busy, Halted, Erro}); end
        total++; if (DIN !== 16'h0000) begin bad++; $display("FAIL reset_din: got %h expected 0000", DIN); end
        total++; if (PC !== 6'd0) begin bad++; $display("FAIL reset_pc: got %0d expected 0", PC); end
        @(negedge Clock);
        Resetn = 1'b1;
    endtask

    task automatic test_single();
        write_word(5'd0, 16'h0001);
        start_prog(6'd1);
        total++; if (Run !== 1'b1 || DIN !== 16'h0001) begin bad++; $display("FAIL single_issue: got run=%b din=%h expected run=1 din=0001", Run, DIN); end
        tick();
        total++; if (Run !== 1'b0 || DIN !== 16'h0001 || Busy !== 1'b1) begin bad++; $display("FAIL single_wait: got run=%b din=%h busy=%b expected 0 0001 1", Run, DIN, Busy); end
        Done = 1'b1;
        tick();
        Done = 1'b0;
        total++; if (Halted !== 1'b1 || PC !== 6'd1 || Erro !== 1'b0) begin bad++; $display("FAIL single_halt: got halted=%b pc=%0d erro=%b expected 1 1 0", Halted, PC, Erro); end
        total++; if (Run !== 1'b0 || DIN !== 16'h0000) begin bad++; $display("FAIL single_halt_out: got run=%b din=%h expected 0 0000", Run, DIN); end
    endtask

    task automatic test_mvi();
        write_word(5'd0, 16'h0040);
        write_word(5'd1, 16'h0005);
        start_prog(6'd2);
        total++; if (Run !== 1'b1 || DIN !== 16'h0040 || PC !== 6'd0) begin bad++; $display("FAIL mvi_issue: got run=%b din=%h pc=%0d expected 1 0040 0", Run, DIN, PC); end
        tick();
        total++; if (Run !== 1'b0 || DIN !== 16'h0005 || PC !== 6'd1) begin bad++; $display("FAIL mvi_imm: got run=%b din=%h pc=%0d expected 0 0005 1", Run, DIN, PC); end
        Done = 1'b1;
        tick();
        Done = 1'b0;
        total++; if (Halted !== 1'b1 || PC !== 6'd2 || Erro !== 1'b0) begin bad++; $display("FAIL mvi_halt: got halted=%b pc=%0d erro=%b expected 1 2 0", Halted, PC, Erro); end
    endtask

    task automatic run_prog3();
        total++; if (Run !== 1'b1 || DIN !== 16'h00C8 || PC !== 6'd0) begin bad++; $display("FAIL b2b_first: got run=%b din=%h pc=%0d expected 1 00c8 0", Run, DIN, PC); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (Run !== 1'b0 || DIN !== 16'h00C8) begin bad++; $display("FAIL b2b_wait1: got run=%b din=%h expected 0 00c8", Run, DIN); end
            if (i == 2) Done = 1'b1;
        end
        tick();
        Done = 1'b0;
        total++; if (Run !== 1'b1 || DIN !== 16'h0101 || PC !== 6'd1) begin bad++; $display("FAIL b2b_second: got run=%b din=%h pc=%0d expected 1 0101 1", Run, DIN, PC); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (Run !== 1'b0 || Halted !== 1'b0) begin bad++; $display("FAIL b2b_wait2: got run=%b halted=%b expected 0 0", Run, Halted); end
            if (i == 2) Done = 1'b1;
        end
        tick();
        Done = 1'b0;
        total++; if (Halted !== 1'b1 || PC !== 6'd2 || Erro !== 1'b0) begin bad++; $display("FAIL b2b_halt: got halted=%b pc=%0d erro=%b expected 1 2 0", Halted, PC, Erro); end
    endtask

    task automatic test_back_to_back();
        write_word(5'd0, 16'h00C8);
        write_word(5'd1, 16'h0101);
        start_prog(6'd2);
        run_prog3();
    endtask

    task automatic test_timeout();
        write_word(5'd0, 16'h0001);
        start_prog(6'd1);
        total++; if (Run !== 1'b1) begin bad++; $display("FAIL to_issue: got run=%b expected 1", Run); end
        for (int i = 0; i < 15; i++) begin
            tick();
            total++; if ({Run, Busy, Erro} !== 3'b010) begin bad++; $display("FAIL to_waiting: cycle %0d got run/busy/erro=%b expected 010", i, {Run, Busy, Erro}); end
        end
        tick();
        total++; if (Erro !== 1'b1 || PC !== 6'd0 || Run !== 1'b0 || DIN !== 16'h0000) begin bad++; $display("FAIL to_erro: got erro=%b pc=%0d run=%b din=%h expected 1 0 0 0000", Erro, PC, Run, DIN); end
        tick();
        total++; if (Erro !== 1'b1 || Busy !== 1'b0) begin bad++; $display("FAIL to_sticky: got erro=%b busy=%b expected 1 0", Erro, Busy); end
        start_prog(6'd1);
        total++; if (Erro !== 1'b0 || Run !== 1'b1) begin bad++; $display("FAIL to_restart: got erro=%b run=%b expected 0 1", Erro, Run); end
        tick();
        Done = 1'b1;
        tick();
        Done = 1'b0;
        total++; if (Halted !== 1'b1 || Erro !== 1'b0 || PC !== 6'd1) begin bad++; $display("FAIL to_rerun_halt: got halted=%b erro=%b pc=%0d expected 1 0 1", Halted, Erro, PC); end
    endtask

    task automatic test_truncated();
        write_word(5'd0, 16'h0040);
        start_prog(6'd1);
        total++; if (Run !== 1'b1 || DIN !== 16'h0040) begin bad++; $display("FAIL trunc_issue: got run=%b din=%h expected 1 0040", Run, DIN); end
        tick();
        total++; if (Erro !== 1'b1 || PC !== 6'd0 || Busy !== 1'b0 || Run !== 1'b0) begin bad++; $display("FAIL trunc_erro: got erro=%b pc=%0d busy=%b run=%b expected 1 0 0 0", Erro, PC, Busy, Run); end
    endtask

    task automatic test_zero_len();
        start_prog(6'd0);
        total++; if (Halted !== 1'b1 || PC !== 6'd0 || Busy !== 1'b0 || Run !== 1'b0 || Erro !== 1'b0) begin bad++; $display("FAIL zero_len: got halted=%b pc=%0d busy=%b run=%b erro=%b expected 1 0 0 0 0", Halted, PC, Busy, Run, Erro); end
    endtask

    task automatic test_busy_ignore();
        write_word(5'd0, 16'h0001);
        start_prog(6'd1);
        tick();
        WrEn = 1'b1; WrAddr = 5'd0; WrData = 16'h0040;
        Start = 1'b1; ProgLen = 6'd3;
        tick();
        WrEn = 1'b0; Start = 1'b0;
        total++; if (Busy !== 1'b1 || PC !== 6'd0 || DIN !== 16'h0001 || Run !== 1'b0) begin bad++; $display("FAIL busy_ignore: got busy=%b pc=%0d din=%h run=%b expected 1 0 0001 0", Busy, PC, DIN, Run); end
        Done = 1'b1;
        tick();
        Done = 1'b0;
        total++; if (Halted !== 1'b1 || PC !== 6'd1) begin bad++; $display("FAIL busy_halt: got halted=%b pc=%0d expected 1 1", Halted, PC); end
        start_prog(6'd1);
        total++; if (DIN !== 16'h0001 || Run !== 1'b1) begin bad++; $display("FAIL busy_mem_kept: got din=%h run=%b expected 0001 1", DIN, Run); end
        tick();
        Done = 1'b1;
        tick();
        Done = 1'b0;
    endtask

    task automatic test_reset_midrun();
        write_word(5'd0, 16'h00C8);
        write_word(5'd1, 16'h0101);
        start_prog(6'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 2) Done = 1'b1;
        end
        tick();
        Done = 1'b0;
        total++; if (Run !== 1'b1 || PC !== 6'd1) begin bad++; $display("FAIL rst_pre: got run=%b pc=%0d expected 1 1", Run, PC); end
        tick();
        Resetn = 1'b0;
        #1;
        total++; if (DIN !== 16'h0000 || PC !== 6'd0) begin bad++; $display("FAIL rst_async_data: got din=%h pc=%0d expected 0000 0", DIN, PC); end
        total++; if ({Run, Busy, Halted, Erro} !== 4'b0000) begin bad++; $display("FAIL rst_async_flags: got %b expected 0000", {Run, Busy, Halted, Erro}); end
        tick();
        Resetn = 1'b1;
        start_prog(6'd2);
        run_prog3();
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        Resetn  = 1'b0;
        Start   = 1'b0;
        ProgLen = '0;
        Done    = 1'b0;
        WrEn    = 1'b0;
        WrAddr  = '0;
        WrData  = '0;

        test_reset();
        test_single();
        test_mvi();
        test_back_to_back();
        test_timeout();
        test_truncated();
        test_zero_len();
        test_busy_ignore();
        test_reset_midrun();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
